// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// PS2_MAKEBREAK_EN widens the FIFO word with break/extended prefix flags.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam int unsigned PS2_DATA_BITS    = 8;
   localparam logic [7:0]  PS2_PREFIX_BREAK = 8'hF0;
   localparam logic [7:0]  PS2_PREFIX_EXT   = 8'hE0;

`ifdef PS2_MAKEBREAK_EN
   typedef struct packed {
      logic                     brk;
      logic                     ext;
      logic [PS2_DATA_BITS-1:0] code;
   } ps2_word_t;
`else
   typedef struct packed {
      logic [PS2_DATA_BITS-1:0] code;
   } ps2_word_t;
`endif

endpackage

// File: rtl/ps2_sync_fifo.sv
// Generic show-ahead FIFO: dout presents the head entry whenever empty=0.
// A push into a full FIFO is accepted only together with a pop.
module ps2_sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deframe, buffer in a FIFO.
// Define PS2_MAKEBREAK_EN to fold F0/E0 prefixes into oBreak/oExt flags.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter  int unsigned SYNC_STAGES    = 2,
   parameter  int unsigned FILTER_LEN     = 4,
   parameter  int unsigned FIFO_DEPTH     = 8,
   parameter  int unsigned TIMEOUT_CYCLES = 20000,
   localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             PS2_CLK,
   input  logic             PS2_DATA,
   input  logic             iRead,
   output logic [7:0]       oData,
   output logic             oBreak,
   output logic             oExt,
   output logic             oValid,
   output logic             oFull,
   output logic [CNT_W-1:0] oCount,
   output logic             oParityErr,
   output logic             oFrameErr,
   output logic             oOverflow
);

   localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned IDX_W = $clog2(PS2_DATA_BITS);

   // Reset asserts asynchronously, releases on a clock edge
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic [1:0]             raw_s;
   logic [1:0]             filt_q;
   logic [FLT_W-1:0]       fcnt_q [2];
   logic                   filt_clk_d;
   logic                   fall_c;
   logic                   bit_c;

   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DATA};
      end
   end

   assign raw_s = {dat_sync[SYNC_STAGES-1], clk_sync[SYNC_STAGES-1]};

   // Index 0 is the clock line, index 1 the data line
   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         filt_q     <= '1;
         fcnt_q[0]  <= '0;
         fcnt_q[1]  <= '0;
         filt_clk_d <= 1'b1;
      end else begin
         filt_clk_d <= filt_q[0];
         for (int i = 0; i < 2; i++) begin
            if (raw_s[i] == filt_q[i]) begin
               fcnt_q[i] <= '0;
            end else if (fcnt_q[i] == FLT_W'(FILTER_LEN - 1)) begin
               filt_q[i] <= raw_s[i];
               fcnt_q[i] <= '0;
            end else begin
               fcnt_q[i] <= fcnt_q[i] + FLT_W'(1);
            end
         end
      end
   end

   assign fall_c = filt_clk_d & ~filt_q[0];
   assign bit_c  = filt_q[1];

   ps2_state_t         state_q, state_n;
   logic [IDX_W-1:0]   idx_q, idx_n;
   logic [7:0]         shift_q, shift_n;
   logic               par_q, par_n;
   logic [TO_W-1:0]    to_cnt_q, to_cnt_n;
   logic               perr_q, perr_n;
   logic               ferr_q, ferr_n;
   logic               ovf_q, ovf_n;
   logic               good_c;
   logic               push_c;
   logic               pop_c;
   ps2_word_t          push_word_c;
   ps2_word_t          head_word;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;

`ifdef PS2_MAKEBREAK_EN
   logic brk_q, brk_n;
   logic ext_q, ext_n;

   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         brk_q <= 1'b0;
         ext_q <= 1'b0;
      end else begin
         brk_q <= brk_n;
         ext_q <= ext_n;
      end
   end
`endif

   always_ff @(posedge Clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         to_cnt_q <= '0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_n;
         idx_q    <= idx_n;
         shift_q  <= shift_n;
         par_q    <= par_n;
         to_cnt_q <= to_cnt_n;
         perr_q   <= perr_n;
         ferr_q   <= ferr_n;
         ovf_q    <= ovf_n;
      end
   end

   // Deframer, timeout and prefix tracking
   always_comb begin
      state_n  = state_q;
      idx_n    = idx_q;
      shift_n  = shift_q;
      par_n    = par_q;
      to_cnt_n = to_cnt_q + TO_W'(1);
      perr_n   = 1'b0;
      ferr_n   = 1'b0;
      good_c   = 1'b0;
      push_c   = 1'b0;
`ifdef PS2_MAKEBREAK_EN
      brk_n    = brk_q;
      ext_n    = ext_q;
`endif

      if (state_q == IDLE || fall_c) to_cnt_n = '0;

      if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
         state_n  = IDLE;
         ferr_n   = 1'b1;
         to_cnt_n = '0;
      end else if (fall_c) begin
         case (state_q)
            IDLE: begin
               if (!bit_c) begin
                  state_n = DATA;
                  idx_n   = '0;
               end
            end
            DATA: begin
               shift_n = {bit_c, shift_q[7:1]};
               idx_n   = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(PS2_DATA_BITS - 1)) state_n = PARITY;
            end
            PARITY: begin
               par_n   = bit_c;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (!(^{shift_q, par_q})) perr_n = 1'b1;
               else if (!bit_c)          ferr_n = 1'b1;
               else                      good_c = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end

`ifdef PS2_MAKEBREAK_EN
      if (perr_n || ferr_n) begin
         brk_n = 1'b0;
         ext_n = 1'b0;
      end
      if (good_c) begin
         if (shift_q == PS2_PREFIX_BREAK) begin
            brk_n = 1'b1;
         end else if (shift_q == PS2_PREFIX_EXT) begin
            ext_n = 1'b1;
         end else begin
            push_c = 1'b1;
            brk_n  = 1'b0;
            ext_n  = 1'b0;
         end
      end
`else
      push_c = good_c;
`endif

      ovf_n = push_c & fifo_full & ~pop_c;
   end

`ifdef PS2_MAKEBREAK_EN
   assign push_word_c = '{brk: brk_q, ext: ext_q, code: shift_q};
`else
   assign push_word_c = '{code: shift_q};
`endif

   assign pop_c = iRead & ~fifo_empty;

   ps2_sync_fifo #(
      .WIDTH ($bits(ps2_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clock),
      .rst_n (rst_n),
      .push  (push_c),
      .pop   (pop_c),
      .din   (push_word_c),
      .dout  (head_word),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Head fields read as zero while the FIFO is empty
   assign oData = fifo_empty ? 8'h00 : head_word.code;
`ifdef PS2_MAKEBREAK_EN
   assign oBreak = fifo_empty ? 1'b0 : head_word.brk;
   assign oExt   = fifo_empty ? 1'b0 : head_word.ext;
`else
   assign oBreak = 1'b0;
   assign oExt   = 1'b0;
`endif
   assign oValid     = ~fifo_empty;
   assign oFull      = fifo_full;
   assign oCount     = fifo_count;
   assign oParityErr = perr_q;
   assign oFrameErr  = ferr_q;
   assign oOverflow  = ovf_q;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver that replaces the ad-hoc PS2_CLK/PS2_DATA sampling inside MiniAlu. It synchronises and glitch-filters both lines, deframes 11-bit PS/2 frames and checks odd parity, start and stop bits. It recovers from stalled frames by timeout and buffers good bytes in a show-ahead FIFO read by the ALU/VGA logic. Errors and overflow are reported as one-cycle pulses.

Parameters:
SYNC_STAGES, 2, flops per input synchroniser (>=2)
FILTER_LEN, 4, consecutive identical synced samples required before filtered PS2_CLK/PS2_DATA change (>=1)
FIFO_DEPTH, 8, byte entries; power of two, >=2
TIMEOUT_CYCLES, 20000, Clock cycles without a filtered PS2_CLK falling edge before a partial frame is aborted
CNT_W, $clog2(FIFO_DEPTH+1), width of oCount (derived, not overridable)

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset  in  1  asynchronous, active-low reset; deassertion is synchronised internally
PS2_CLK  in  1  raw PS/2 clock pin (asynchronous)
PS2_DATA  in  1  raw PS/2 data pin (asynchronous)
iRead  in  1  pop head entry when oValid=1
oData  out  8  FIFO head scan code
oBreak  out  1  head entry was preceded by F0 (PS2_MAKEBREAK_EN only, else 0)
oExt  out  1  head entry was preceded by E0 (PS2_MAKEBREAK_EN only, else 0)
oValid  out  1  FIFO not empty
oFull  out  1  FIFO full
oCount  out  CNT_W  entries held
oParityErr  out  1  one-cycle pulse: parity check failed
oFrameErr  out  1  one-cycle pulse: bad stop bit or timeout
oOverflow  out  1  one-cycle pulse: good byte dropped because FIFO was full

Behaviour:
- Reset (asynchronous, Reset=0): FSM=IDLE, FIFO empty, all outputs 0, filtered lines=1, timeout counter=0, prefix flags cleared. Reset mid-frame discards the partial frame.
- Front end: SYNC_STAGES flops per line, then a FILTER_LEN stability filter. A fall event is a 1->0 transition of filtered PS2_CLK, and data is sampled from filtered PS2_DATA in the same cycle. A low pulse shorter than FILTER_LEN cycles produces no event.
- FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE. All transitions are taken on fall events only, except timeout.
  - IDLE: fall with data=0 -> DATA, bit index=0. Fall with data=1 is ignored.
  - DATA: shift in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if data=1 and XOR(8 data bits, parity)=1, the byte is good. If parity fails, pulse oParityErr. Otherwise, if stop=0, pulse oFrameErr. Parity error has priority over frame error, and only one error pulse is issued per frame. The FSM returns to IDLE in all cases.
- Timeout: the counter clears on every fall event and whenever the FSM is in IDLE. If it reaches TIMEOUT_CYCLES outside IDLE, the FSM goes to IDLE and pulses oFrameErr.
- Push: a good byte is written in the STOP fall cycle, and oValid rises on the next Clock edge. Pin-to-oValid latency is SYNC_STAGES+FILTER_LEN+1 cycles after the stop-bit falling pin edge.
- FIFO (show-ahead):
  - oData, oBreak and oExt present the head entry while oValid=1.
  - iRead with oValid=0 is ignored.
  - Push when full with no pop: drop the byte and pulse oOverflow.
  - Simultaneous push and pop when full: both happen and oCount is unchanged.
  - Simultaneous push and pop when empty: the push wins, so oCount=1.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro PS2_MAKEBREAK_EN.
- Defined:
  - A good byte 8'hF0 sets the break flag and 8'hE0 sets the ext flag; neither prefix byte is pushed.
  - The next non-prefix good byte is pushed with {break, ext}, and then both flags clear.
  - Any parity error, frame error or timeout clears both flags.
  - An overflow-dropped byte also clears both flags.
  - FIFO word width is 10 bits.
- Undefined: every good byte, including F0 and E0, is pushed raw. oBreak and oExt are tied to 0, and the FIFO word width is 8 bits.

Decomposition:
- Package ps2_pkg:
  - FSM state enum {IDLE, DATA, PARITY, STOP}
  - PS2_PREFIX_BREAK=8'hF0, PS2_PREFIX_EXT=8'hE0
  - PS2_DATA_BITS=8
- Sub-module ps2_sync_fifo: generic show-ahead FIFO with parameters WIDTH and DEPTH and ports push, pop, din, dout, count, full, empty. ps2_rx_fifo instantiates it with WIDTH=8 or 10.
- Synchroniser and filter stay inline.

Test Plan:
- Basic frame: PS/2 half-period 40 cycles, frame 0x1C (start 0, bits LSB first, parity 0, stop 1) -> oValid=1, oData=8'h1C, oCount=1; iRead for one cycle -> oValid=0, oCount=0.
- Parity error: send 0x1C with parity 1 -> oParityErr high for exactly 1 cycle, oValid stays 0. A following 0x29 frame (parity 0) is received as 8'h29.
- Overflow: FIFO_DEPTH=4, five frames 0x01..0x05 with no reads -> oFull=1 and oCount=4 after the 4th; one oOverflow pulse on the 5th. Four reads return 01,02,03,04.
- Timeout/recovery: TIMEOUT_CYCLES=500, send start plus 3 data bits, then hold PS2_CLK=1 for 600 cycles -> one oFrameErr pulse, FSM in IDLE. The next full 0x29 frame yields oData=8'h29.
- Glitch and reset: a 2-cycle low pulse on PS2_CLK in IDLE -> no state change, no pulses. Reset=0 asserted after 5 bits of a frame -> outputs 0 immediately. A clean 0x1C frame after release is received correctly.
- PS2_MAKEBREAK_EN: frames E0, F0, 0x6B -> exactly one entry {oExt=1, oBreak=1, oData=8'h6B}. Without the macro, the same stimulus gives three entries E0, F0, 6B with oBreak=oExt=0.
